// File: rtl/param_counter_shift_reg.sv
// Serial-in shift register with a frame bit counter: every FRAME_LEN counted
// edges the (next-state) shift contents are captured into frameOut with a pulse.
module param_counter_shift_reg #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 3,
    parameter int FRAME_LEN = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    input  logic              iz0,
    input  logic              cen,
    input  logic              shen,
    output logic              co,
    output logic [DATA_W-1:0] parOut,
    output logic [DATA_W-1:0] frameOut,
    output logic              frameValid,
    output logic [CNT_W-1:0]  cnt
);

    if (DATA_W < 2) begin : g_bad_data_w
        $fatal(1, "param_counter_shift_reg: DATA_W must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "param_counter_shift_reg: CNT_W must be >= 1");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > (1 << CNT_W)) begin : g_bad_frame_len
        $fatal(1, "param_counter_shift_reg: FRAME_LEN must be in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] par_q,   par_d;
    logic [DATA_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              fv_q,    fv_d;
    logic              co_w;

    // Terminal count is suppressed by iz0 and rst so neither can launch a capture.
    assign co_w = cen & (cnt_q == LAST) & ~iz0 & ~rst;

    always_comb begin
        par_d   = par_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        fv_d    = co_w;

        if (shen) begin
            if (MSB_FIRST) par_d = {par_q[DATA_W-2:0], serIn};
            else           par_d = {serIn, par_q[DATA_W-1:1]};
        end

        if (iz0)
            cnt_d = '0;
        else if (cen)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);

        // Capture includes the bit shifted on this same edge.
        if (co_w)
            frame_d = par_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q   <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            par_q   <= par_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
        end
    end

    assign co         = co_w;
    assign parOut     = par_q;
    assign frameOut   = frame_q;
    assign frameValid = fv_q;
    assign cnt        = cnt_q;

endmodule

// File: doc/param_counter_shift_reg.md
PARAM_COUNTER_SHIFT_REG -- requirements
Module: param_counter_shift_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, shift-register width (legal range >=2).
REQ-002 SHALL provide parameter CNT_W, default 3, bit-counter width (legal range >=1).
REQ-003 SHALL provide parameter FRAME_LEN, default 8, bits per frame (legal range 1..2**CNT_W); an illegal value SHALL stop elaboration.
REQ-004 SHALL provide parameter MSB_FIRST, default 1; 1 = shift left (first bit ends at MSB), 0 = shift right (first bit ends at LSB).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 serIn  input  1  serial data bit.
REQ-009 iz0  input  1  synchronous counter initialise-to-zero.
REQ-010 cen  input  1  counter enable.
REQ-011 shen  input  1  shift enable.
REQ-012 co  output  1  combinational terminal-count carry.
REQ-013 parOut  output  DATA_W  live shift-register contents.
REQ-014 frameOut  output  DATA_W  captured completed frame.
REQ-015 frameValid  output  1  registered one-cycle frame-complete pulse.
REQ-016 cnt  output  CNT_W  current counter value.

Function
REQ-017 Priority per edge SHALL be rst > iz0 > normal operation (cen, shen).
REQ-018 shen=1, MSB_FIRST=1: parOut <= {parOut[DATA_W-2:0], serIn}.
REQ-019 shen=1, MSB_FIRST=0: parOut <= {serIn, parOut[DATA_W-1:1]}.
REQ-020 shen=0: parOut SHALL hold.
REQ-021 cen=1, cnt<FRAME_LEN-1: cnt <= cnt+1.
REQ-022 cen=1, cnt==FRAME_LEN-1: cnt <= 0 (wrap); no value >=FRAME_LEN is ever reached.
REQ-023 cen=0: cnt SHALL hold.
REQ-024 co = cen & (cnt==FRAME_LEN-1) & ~iz0 & ~rst, combinational, no added latency.
REQ-025 On an edge with co=1: frameOut <= next-state parOut (includes the bit shifted that same edge when shen=1; otherwise current parOut).
REQ-026 frameValid <= co each edge, so it is high exactly the cycle after co; back-to-back frames (FRAME_LEN=1, cen held) SHALL keep frameValid continuously high.
REQ-027 frameOut SHALL hold between captures; parOut may keep shifting without disturbing it.
REQ-028 iz0=1: cnt <= 0, co forced 0, frameValid <= 0; parOut still shifts per shen; frameOut holds.
REQ-029 cen and shen are independent; cen without shen counts without shifting, shen without cen shifts without counting.
REQ-030 Inputs X-free during rst=0 is a usage requirement; no internal X-masking required.

Reset
REQ-031 On rst=1 at an edge: parOut=0, frameOut=0, cnt=0, frameValid=0; co=0 while rst=1.
REQ-032 Reset mid-frame SHALL discard partial count and bits; the next frame starts at cnt=0 after rst deasserts.
REQ-033 No state SHALL change without a clk edge (no asynchronous paths).

Verification
REQ-034 Defaults, rst 1 cycle, cen=shen=1, serIn sequence 1,0,1,0,1,0,0,1 -> co high on 8th edge (cnt=7), cnt returns to 0, frameValid high one cycle after, frameOut=0xA9.
REQ-035 Same stimulus with MSB_FIRST=0 -> frameOut=0x95, identical co/frameValid timing.
REQ-036 FRAME_LEN=5, CNT_W=3, cen held 12 cycles -> cnt 0,1,2,3,4,0,1,...; co on cnt=4 cycles only; two frameValid pulses.
REQ-037 iz0=1 asserted at cnt=6 with cen=1 -> cnt=0 next cycle, no co, no frameValid; parOut continues shifting.
REQ-038 rst asserted at cnt=5 mid-frame -> all outputs 0 next cycle; subsequent full 8-bit frame captured correctly.
REQ-039 shen=0 with cen=1 for 8 cycles after loading 0xA9 -> frameValid pulse with frameOut=0xA9 (unshifted parOut), parOut unchanged.
